// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg : shared FSM encoding, LFSR defaults and feedback helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } seq_state_e;

  localparam logic [7:0] TAP_MASK_DEFAULT = 8'hB8;
  localparam logic [7:0] SEED_DEFAULT_VAL = 8'h01;

  // Callers zero-extend narrower states and masks; parity is unaffected.
  function automatic logic lfsr_feedback(input logic [31:0] state, input logic [31:0] mask);
    return ^(state & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_core.sv
// ---------------------------------------------------------------------------
// lfsr_core : Fibonacci LFSR state register with seed load and shift enable
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAP_MASK     = WIDTH'(TAP_MASK_DEFAULT),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(SEED_DEFAULT_VAL)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic [WIDTH-1:0] state
);

  logic fb;

  assign fb = lfsr_feedback(32'(state), 32'(TAP_MASK));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= SEED_DEFAULT;
    end else if (load) begin
      state <= load_data;
    end else if (shift_en) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_word_sequencer.sv
// ---------------------------------------------------------------------------
// lfsr_word_sequencer : seeds an LFSR and emits runs of words over valid/ready
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_word_sequencer
  import lfsr_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] TAP_MASK        = WIDTH'(TAP_MASK_DEFAULT),
  parameter logic [WIDTH-1:0] SEED_DEFAULT    = WIDTH'(SEED_DEFAULT_VAL),
  parameter int               SHIFTS_PER_WORD = 8,
  parameter int               CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_ack,
  output logic             seed_err,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] state_q
);

  localparam logic [7:0] SHIFT_LAST = 8'(SHIFTS_PER_WORD - 1);

  seq_state_e       st, st_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [7:0]       shift_cnt, shift_cnt_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [WIDTH-1:0] state_shifted;
  logic             load, shift_en;
  logic             seed_ack_nxt, seed_err_nxt;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAP_MASK     (TAP_MASK),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_core (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (load),
    .load_data (seed_data),
    .shift_en  (shift_en),
    .state     (state_q)
  );

  // Value the core will hold after this cycle's shift; snapshotted into out_data.
  assign state_shifted = {state_q[WIDTH-2:0], lfsr_feedback(32'(state_q), 32'(TAP_MASK))};

  assign busy      = (st != ST_IDLE);
  assign done      = (st == ST_FINISH);
  assign out_valid = (st == ST_PRESENT);

  always_comb begin
    st_nxt        = st;
    remaining_nxt = remaining;
    shift_cnt_nxt = shift_cnt;
    out_data_nxt  = out_data;
    load          = 1'b0;
    shift_en      = 1'b0;
    seed_ack_nxt  = 1'b0;
    seed_err_nxt  = 1'b0;

    if (seed_valid) begin
      if (st == ST_IDLE && seed_data != '0) begin
        load         = 1'b1;
        seed_ack_nxt = 1'b1;
      end else begin
        seed_err_nxt = 1'b1;
      end
    end

    case (st)
      ST_IDLE: begin
        // A seed request in the same cycle wins and the start is dropped.
        if (start && !seed_valid) begin
          if (num_words == '0) begin
            st_nxt = ST_FINISH;
          end else begin
            remaining_nxt = num_words;
            shift_cnt_nxt = 8'd0;
            st_nxt        = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        shift_en      = 1'b1;
        shift_cnt_nxt = shift_cnt + 8'd1;
        if (abort) begin
          st_nxt = ST_FINISH;
        end else if (shift_cnt == SHIFT_LAST) begin
          out_data_nxt = state_shifted;
          st_nxt       = ST_PRESENT;
        end
      end

      ST_PRESENT: begin
        if (out_ready) begin
          if (remaining != '0) begin
            remaining_nxt = remaining - CNT_W'(1);
          end
          if (remaining <= CNT_W'(1)) begin
            st_nxt = ST_FINISH;
          end else begin
            shift_cnt_nxt = 8'd0;
            st_nxt        = ST_SHIFT;
          end
        end
        if (abort) begin
          st_nxt = ST_FINISH;
        end
      end

      ST_FINISH: begin
        st_nxt = ST_IDLE;
      end

      default: begin
        st_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st        <= ST_IDLE;
      remaining <= '0;
      shift_cnt <= 8'd0;
      out_data  <= '0;
      seed_ack  <= 1'b0;
      seed_err  <= 1'b0;
    end else begin
      st        <= st_nxt;
      remaining <= remaining_nxt;
      shift_cnt <= shift_cnt_nxt;
      out_data  <= out_data_nxt;
      seed_ack  <= seed_ack_nxt;
      seed_err  <= seed_err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_word_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lfsr_word_sequencer : self-checking bench with a word-level LFSR model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lfsr_word_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        seed_valid = 1'b0;
  logic [7:0]  seed_data = 8'h00;
  logic        seed_ack, seed_err;
  logic        start = 1'b0;
  logic [15:0] num_words = 16'd0;
  logic        abort = 1'b0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data, state_q;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_state;

  lfsr_word_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ack   (seed_ack),
    .seed_err   (seed_err),
    .start      (start),
    .num_words  (num_words),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .state_q    (state_q)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] seed;
    int         words;
    logic       seed_ok;
    logic [7:0] first_word;
    logic [7:0] last_word;
  } vec_t;

  vec_t tbl[4];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One LFSR step straight from the polynomial: new bit is parity of tapped bits.
  function automatic logic [7:0] m_shift(input logic [7:0] s);
    return {s[6:0], 1'($countones(s & 8'hB8) % 2)};
  endfunction

  function automatic logic [7:0] m_word(input logic [7:0] s);
    logic [7:0] v = s;
    for (int k = 0; k < 8; k++) v = m_shift(v);
    return v;
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    model_state = 8'h01;
  endtask

  task automatic apply_seed(input logic [7:0] d, input logic exp_ok);
    seed_valid = 1'b1;
    seed_data  = d;
    step();
    seed_valid = 1'b0;
    check("seed_ack", 32'(seed_ack), 32'(exp_ok));
    check("seed_err", 32'(seed_err), 32'(!exp_ok));
    if (exp_ok) model_state = d;
    check("seed_state", 32'(state_q), 32'(model_state));
  endtask

  task automatic run_words(input int n, input int pct, input bit allow_abort,
                           output logic [7:0] first_w, output logic [7:0] last_w,
                           output int hs);
    int         wait_cnt;
    bit         seen, expect_done, finished, rdy, abt;
    logic [7:0] held, exp_w;
    hs = 0; seen = 0; finished = 0; held = '0;
    first_w = '0; last_w = '0;
    expect_done = (n == 0);
    num_words = 16'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_cnt = 1;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      check("done", 32'(done), 32'(expect_done));
      if (expect_done) begin
        check("valid_at_done", 32'(out_valid), 0);
        check("busy_at_done", 32'(busy), 1);
        finished = 1;
      end else begin
        rdy = ($urandom_range(99) < pct);
        abt = 1'b0;
        if (out_valid) begin
          exp_w = m_word(model_state);
          if (!seen) begin
            check("latency", 32'(wait_cnt), 9);
            check("word", 32'(out_data), 32'(exp_w));
            held = out_data;
            seen = 1;
          end else begin
            check("hold_data", 32'(out_data), 32'(held));
            check("hold_state", 32'(state_q), 32'(exp_w));
          end
          abt = allow_abort && ($urandom_range(7) == 0);
          if (rdy) begin
            hs++;
            if (hs == 1) first_w = out_data;
            last_w   = out_data;
            seen     = 0;
            wait_cnt = 0;
            if (hs == n) expect_done = 1;
          end
          if (rdy || abt) model_state = exp_w;
          if (abt) expect_done = 1;
        end
        out_ready = rdy;
        abort     = abt;
        step();
        wait_cnt++;
        out_ready = 1'b0;
        abort     = 1'b0;
      end
    end
    check("run_finished", 32'(finished), 1);
    step();
    check("busy_after", 32'(busy), 0);
    check("state_after", 32'(state_q), 32'(model_state));
  endtask

  initial begin
    logic [7:0] fw, lw;
    int         hs;
    bit         stable;

    tbl[0] = '{seed: 8'h00, words: 2, seed_ok: 1'b0, first_word: 8'h1C, last_word: 8'h4B};
    tbl[1] = '{seed: 8'h1C, words: 1, seed_ok: 1'b1, first_word: 8'h4B, last_word: 8'h4B};
    tbl[2] = '{seed: 8'hA5, words: 1, seed_ok: 1'b1, first_word: 8'h4E, last_word: 8'h4E};
    tbl[3] = '{seed: 8'h01, words: 1, seed_ok: 1'b1, first_word: 8'h1C, last_word: 8'h1C};

    // Reset defaults
    do_reset();
    check("rst_state", 32'(state_q), 32'h01);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ack", 32'(seed_ack), 0);
    check("rst_err", 32'(seed_err), 0);
    check("rst_data", 32'(out_data), 0);

    // Table-driven seed + run vectors
    for (int i = 0; i < 4; i++) begin
      apply_seed(tbl[i].seed, tbl[i].seed_ok);
      run_words(tbl[i].words, 100, 0, fw, lw, hs);
      check("tbl_first", 32'(fw), 32'(tbl[i].first_word));
      check("tbl_last", 32'(lw), 32'(tbl[i].last_word));
      check("tbl_count", 32'(hs), 32'(tbl[i].words));
    end

    // Backpressure: word held for 20 stalled cycles
    do_reset();
    num_words = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("bp_valid", 32'(out_valid), 1);
    check("bp_data", 32'(out_data), 32'h1C);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_data !== 8'h1C || state_q !== 8'h1C || out_valid !== 1'b1) stable = 0;
    end
    check("bp_stable", 32'(stable), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_done", 32'(done), 1);
    check("bp_valid_off", 32'(out_valid), 0);
    step();
    check("bp_single_done", 32'(done), 0);
    check("bp_idle", 32'(busy), 0);

    // Seed request while busy
    do_reset();
    num_words = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    seed_valid = 1'b1;
    seed_data  = 8'hA5;
    step();
    seed_valid = 1'b0;
    check("busy_seed_err", 32'(seed_err), 1);
    check("busy_seed_ack", 32'(seed_ack), 0);
    repeat (6) step();
    check("busy_seed_valid", 32'(out_valid), 1);
    check("busy_seed_word", 32'(out_data), 32'h1C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("busy_seed_done", 32'(done), 1);
    step();

    // Seed and start together: seed wins, start dropped
    seed_valid = 1'b1;
    seed_data  = 8'h3C;
    start      = 1'b1;
    num_words  = 16'd1;
    step();
    seed_valid = 1'b0;
    start      = 1'b0;
    check("ss_ack", 32'(seed_ack), 1);
    check("ss_busy", 32'(busy), 0);
    step();
    check("ss_busy2", 32'(busy), 0);
    check("ss_state", 32'(state_q), 32'h3C);

    // Abort in the 4th shift cycle, then continue the sequence
    do_reset();
    num_words = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done", 32'(done), 1);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_state", 32'(state_q), 32'(m_shift(m_shift(m_shift(m_shift(8'h01))))));
    step();
    check("abort_idle", 32'(busy), 0);
    model_state = state_q;
    check("abort_model", 32'(model_state), 32'h11);
    run_words(1, 100, 0, fw, lw, hs);
    check("abort_cont_count", 32'(hs), 1);

    // Reset while presenting
    num_words = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("rp_valid", 32'(out_valid), 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    model_state = 8'h01;
    check("rp_state", 32'(state_q), 32'h01);
    check("rp_valid_off", 32'(out_valid), 0);
    check("rp_busy", 32'(busy), 0);
    check("rp_data", 32'(out_data), 0);

    // Degenerate empty run
    run_words(0, 100, 0, fw, lw, hs);
    check("empty_count", 32'(hs), 0);

    // Randomised runs against the word-level model
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(2) == 0) begin
        if ($urandom_range(3) == 0) apply_seed(8'h00, 1'b0);
        else apply_seed(8'($urandom_range(255, 1)), 1'b1);
      end
      run_words(int'($urandom_range(3)), int'($urandom_range(100, 30)), 1, fw, lw, hs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
